// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, types and default ROM image for the fetch stage
package fetch_pkg;
  localparam int ADDR_W = 10;
  localparam int INST_W = 9;
  typedef logic [ADDR_W-1:0] pc_t;
  typedef logic [INST_W-1:0] inst_t;
  localparam pc_t   DEF_ADDR_A = 10'd50;
  localparam inst_t DEF_INST_A = 9'b000_001_100;
  localparam pc_t   DEF_ADDR_B = 10'd100;
  localparam inst_t DEF_INST_B = 9'b001_011_010;
endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: control-in / PC-and-instruction-out bundle of the fetch stage
interface inst_fetch_if #(
  parameter int ADDR_W = fetch_pkg::ADDR_W,
  parameter int INST_W = fetch_pkg::INST_W
);
  logic              Start;
  logic              JmpEq;
  logic              JmpNe;
  logic              Zero;
  logic [ADDR_W-1:0] DestAddr;
  logic [ADDR_W-1:0] ProgCtr;
  logic [INST_W-1:0] InstOut;
  modport master (output Start, JmpEq, JmpNe, Zero, DestAddr, input ProgCtr, InstOut);
  modport slave  (input Start, JmpEq, JmpNe, Zero, DestAddr, output ProgCtr, InstOut);
endinterface

// File: rtl/inst_rom.sv
// inst_rom: asynchronous-read instruction ROM with built-in default image
module inst_rom import fetch_pkg::*; #(
  parameter int ADDR_W    = fetch_pkg::ADDR_W,
  parameter int INST_W    = fetch_pkg::INST_W,
  parameter     INIT_FILE = ""
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [INST_W-1:0] inst_o
);
  always_comb
    inst_o = addr_i == ADDR_W'(DEF_ADDR_A) ? INST_W'(DEF_INST_A) :
             addr_i == ADDR_W'(DEF_ADDR_B) ? INST_W'(DEF_INST_B) : '0;
endmodule

// File: rtl/prog_ctr.sv
// prog_ctr: program counter register with restart / branch / increment selection
module prog_ctr import fetch_pkg::*; #(
  parameter int ADDR_W = fetch_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              jmp_eq_i,
  input  logic              jmp_ne_i,
  input  logic              zero_i,
  input  logic [ADDR_W-1:0] dest_i,
  output logic [ADDR_W-1:0] pc_o
);
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              take;
  // next PC: restart beats branch, branch beats increment (wraps naturally)
  always_comb begin
    take = (jmp_eq_i & zero_i) | (jmp_ne_i & ~zero_i);
    pc_d = start_i ? '0 : take ? dest_i : pc_q + 1'b1;
  end
  // PC register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc_q <= '0;
    else        pc_q <= pc_d;
  assign pc_o = pc_q;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC plus instruction ROM; PC addresses the ROM combinationally
module inst_fetch import fetch_pkg::*; #(
  parameter int ADDR_W    = fetch_pkg::ADDR_W,
  parameter int INST_W    = fetch_pkg::INST_W,
  parameter     INIT_FILE = ""
) (
  input  logic        Clk,
  input  logic        Reset,
  inst_fetch_if.slave bus
);
  prog_ctr #(.ADDR_W(ADDR_W)) u_pc (
    .clk     (Clk),
    .rst_n   (Reset),
    .start_i (bus.Start),
    .jmp_eq_i(bus.JmpEq),
    .jmp_ne_i(bus.JmpNe),
    .zero_i  (bus.Zero),
    .dest_i  (bus.DestAddr),
    .pc_o    (bus.ProgCtr)
  );
  inst_rom #(.ADDR_W(ADDR_W), .INST_W(INST_W), .INIT_FILE(INIT_FILE)) u_rom (
    .addr_i(bus.ProgCtr),
    .inst_o(bus.InstOut)
  );
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed vectors with a queued scoreboard checked by a monitor
module tb_inst_fetch import fetch_pkg::*; ;
  typedef struct {
    string name;
    pc_t   pc;
    inst_t inst;
  } exp_t;

  logic   Clk = 1'b0;
  logic   Reset;
  exp_t   sb[$];
  event   chk_ev;
  int     n_vec = 0;
  int     n_err = 0;

  inst_fetch_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();
  inst_fetch #(.ADDR_W(ADDR_W), .INST_W(INST_W), .INIT_FILE("")) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  function automatic inst_t rom_m(input pc_t a);
    return a == 10'd50 ? 9'b000_001_100 : a == 10'd100 ? 9'b001_011_010 : 9'd0;
  endfunction

  task automatic expect_now(input string nm, input pc_t epc);
    sb.push_back('{nm, epc, rom_m(epc)});
    -> chk_ev;
  endtask

  task automatic step(input string nm, input logic st, eq, ne, z, input pc_t d, input pc_t epc);
    bus.Start = st; bus.JmpEq = eq; bus.JmpNe = ne; bus.Zero = z; bus.DestAddr = d;
    sb.push_back('{nm, epc, rom_m(epc)});
    @(posedge Clk);
    #1 -> chk_ev;
    @(negedge Clk);
  endtask

  initial forever begin
    exp_t e;
    @(chk_ev);
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_sample: ProgCtr=%0d InstOut=%b with nothing expected", bus.ProgCtr, bus.InstOut);
    end else begin
      e = sb.pop_front();
      if (bus.ProgCtr !== e.pc || bus.InstOut !== e.inst) begin
        n_err++;
        $display("FAIL %s: got ProgCtr=%0d InstOut=%b, want ProgCtr=%0d InstOut=%b",
                 e.name, bus.ProgCtr, bus.InstOut, e.pc, e.inst);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b0;
    bus.Start = 0; bus.JmpEq = 0; bus.JmpNe = 0; bus.Zero = 0; bus.DestAddr = '0;
    #2 expect_now("reset", 10'd0);
    @(negedge Clk);
    Reset = 1'b1;
    for (int i = 1; i <= 15; i++) step($sformatf("inc%0d", i), 0, 0, 0, 0, 10'd0, pc_t'(i));
    step("jmpeq_taken",      0, 1, 0, 1, 10'd100,  10'd100);
    step("jmpne_taken",      0, 0, 1, 0, 10'd50,   10'd50);
    step("jmpne_not_taken",  0, 0, 1, 1, 10'd77,   10'd51);
    step("jmpeq_not_taken",  0, 1, 0, 0, 10'd77,   10'd52);
    step("both_zero0",       0, 1, 1, 0, 10'd200,  10'd200);
    step("both_zero1",       0, 1, 1, 1, 10'd100,  10'd100);
    step("start_wins",       1, 1, 0, 1, 10'd100,  10'd0);
    step("jmp_1023",         0, 1, 0, 1, 10'd1023, 10'd1023);
    step("wrap",             0, 0, 0, 0, 10'd0,    10'd0);
    step("to_100",           0, 0, 1, 0, 10'd100,  10'd100);
    Reset = 1'b0;
    bus.Start = 1; bus.JmpEq = 1; bus.Zero = 1; bus.DestAddr = 10'd50;
    #1 expect_now("async_reset", 10'd0);
    #1 Reset = 1'b1;
    step("after_reset",      0, 0, 0, 0, 10'd0,    10'd1);
    step("after_reset2",     0, 0, 0, 0, 10'd0,    10'd2);
    #2;
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
